// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline boundary registers: NOP encoding,
// per-boundary payload widths and the default performance-counter width.
package pipe_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Payload widths for a 16-bit datapath (instruction, PC, operands, control)
    localparam int unsigned IFID_W  = 32;
    localparam int unsigned IDEX_W  = 64;
    localparam int unsigned EXMEM_W = 48;
    localparam int unsigned MEMWB_W = 40;

    localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_reg_en.sv
// Generic register with synchronous reset value, load-constant and load enable.
// Priority: rst > ld_const > en.
module pipe_reg_en #(
    parameter int unsigned           WIDTH   = 16,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld_const,
    input  logic [WIDTH-1:0] const_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (ld_const) begin
            q <= const_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// One pipeline boundary: payload + valid with stall/flush, plus saturating
// stall and squash counters for hazard-unit debug.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter int unsigned      CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam int unsigned     BUNDLE_W   = WIDTH + 1;
    localparam logic [BUNDLE_W-1:0] BUBBLE_BUNDLE = {1'b0, BUBBLE_VAL};
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [BUNDLE_W-1:0] bundle_q;
    logic                stall_hit;
    logic                squash_hit;

    // Valid rides in the MSB so flush/reset clear it together with the payload
    pipe_reg_en #(
        .WIDTH   (BUNDLE_W),
        .RST_VAL (BUBBLE_BUNDLE)
    ) u_bundle (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall),
        .ld_const  (flush),
        .const_val (BUBBLE_BUNDLE),
        .d         ({in_valid, in_data}),
        .q         (bundle_q)
    );

    assign out_valid = bundle_q[WIDTH];
    assign out_data  = bundle_q[WIDTH-1:0];

    // Only real instructions are counted; flush takes precedence over stall
    assign squash_hit = flush & out_valid;
    assign stall_hit  = stall & ~flush & out_valid;

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (stall_hit && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (squash_hit && (squash_cnt != CNT_MAX)) begin
                squash_cnt <= squash_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a 16-bit instance and a 37-bit/4-bit-counter
// instance driven in lockstep and checked against a behavioural model.
module tb_pipe_stage_reg;

    localparam logic [36:0] B_BUB = 37'h1_0000_0001;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, clr_cnt;
    logic [36:0] in_data;

    logic        a_valid;
    logic [15:0] a_data, a_sc, a_qc;
    logic        b_valid;
    logic [36:0] b_data;
    logic [3:0]  b_sc, b_qc;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(16), .BUBBLE_VAL(16'h0000), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[15:0]), .clr_cnt(clr_cnt),
        .out_valid(a_valid), .out_data(a_data),
        .stall_cnt(a_sc), .squash_cnt(a_qc)
    );

    pipe_stage_reg #(.WIDTH(37), .BUBBLE_VAL(B_BUB), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
        .out_valid(b_valid), .out_data(b_data),
        .stall_cnt(b_sc), .squash_cnt(b_qc)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state, index 0 = instance A, 1 = instance B
    logic        mv   [2];
    logic [63:0] md   [2];
    longint      ms   [2];
    longint      mq   [2];
    longint      cap  [2];
    logic [63:0] bub  [2];
    logic [63:0] mask [2];

    typedef struct {
        logic        rst, stall, flush, in_valid, clr;
        logic [15:0] data;
        logic        exp_valid;
        logic [15:0] exp_data, exp_sc, exp_qc;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic r, s, f, iv, c, input logic [15:0] d,
                                input logic ev, input logic [15:0] ed, es, eq);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.in_valid = iv; v.clr = c; v.data = d;
        v.exp_valid = ev; v.exp_data = ed; v.exp_sc = es; v.exp_qc = eq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, f, iv, c, input logic [36:0] d);
        rst = r; stall = s; flush = f; in_valid = iv; clr_cnt = c; in_data = d;
    endtask

    function automatic longint sat_add(input longint x, input longint lim);
        return (x + 1 > lim) ? lim : x + 1;
    endfunction

    // Apply the rules to pre-edge model state
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mv[k] = 1'b0; md[k] = bub[k]; ms[k] = 0; mq[k] = 0;
            end else begin
                if (clr_cnt) begin
                    ms[k] = 0; mq[k] = 0;
                end else if (flush && mv[k]) begin
                    mq[k] = sat_add(mq[k], cap[k]);
                end else if (stall && mv[k]) begin
                    ms[k] = sat_add(ms[k], cap[k]);
                end
                if (flush) begin
                    mv[k] = 1'b0; md[k] = bub[k];
                end else if (!stall) begin
                    mv[k] = in_valid; md[k] = 64'(in_data) & mask[k];
                end
            end
        end
    endtask

    task automatic chk_model();
        chk("a_valid", 64'(a_valid), 64'(mv[0]));
        chk("a_data",  64'(a_data),  md[0]);
        chk("a_stall_cnt",  64'(a_sc), 64'(ms[0]));
        chk("a_squash_cnt", 64'(a_qc), 64'(mq[0]));
        chk("b_valid", 64'(b_valid), 64'(mv[1]));
        chk("b_data",  64'(b_data),  md[1]);
        chk("b_stall_cnt",  64'(b_sc), 64'(ms[1]));
        chk("b_squash_cnt", 64'(b_qc), 64'(mq[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_model();
    endtask

    initial begin
        logic [36:0] rd;

        cap[0] = 65535;        cap[1] = 15;
        bub[0] = 64'h0;        bub[1] = 64'(B_BUB);
        mask[0] = 64'hFFFF;    mask[1] = 64'h1F_FFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            mv[k] = 1'b0; md[k] = bub[k]; ms[k] = 0; mq[k] = 0;
        end
        drive(1, 0, 0, 0, 0, 37'h0);

        //           rst stl fl iv clr data      ev data      sc     qc
        tbl[0]  = mk(1, 0, 0, 1, 0, 16'hA5C3, 0, 16'h0000, 16'd0, 16'd0);
        tbl[1]  = mk(1, 0, 0, 1, 0, 16'hA5C3, 0, 16'h0000, 16'd0, 16'd0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 16'hA5C3, 1, 16'hA5C3, 16'd0, 16'd0);
        tbl[3]  = mk(0, 0, 0, 1, 0, 16'h1234, 1, 16'h1234, 16'd0, 16'd0);
        tbl[4]  = mk(0, 1, 0, 1, 0, 16'hFFFF, 1, 16'h1234, 16'd1, 16'd0);
        tbl[5]  = mk(0, 1, 0, 1, 0, 16'hFFFF, 1, 16'h1234, 16'd2, 16'd0);
        tbl[6]  = mk(0, 1, 0, 1, 0, 16'hFFFF, 1, 16'h1234, 16'd3, 16'd0);
        tbl[7]  = mk(0, 0, 0, 1, 0, 16'hFFFF, 1, 16'hFFFF, 16'd3, 16'd0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 16'h00F0, 1, 16'h00F0, 16'd3, 16'd0);
        tbl[9]  = mk(0, 1, 1, 1, 0, 16'h0BAD, 0, 16'h0000, 16'd3, 16'd1);
        tbl[10] = mk(0, 1, 0, 1, 0, 16'h5555, 0, 16'h0000, 16'd3, 16'd1);
        tbl[11] = mk(0, 1, 0, 1, 0, 16'h5555, 0, 16'h0000, 16'd3, 16'd1);
        tbl[12] = mk(0, 1, 0, 1, 0, 16'h5555, 0, 16'h0000, 16'd3, 16'd1);
        tbl[13] = mk(0, 1, 0, 1, 0, 16'h5555, 0, 16'h0000, 16'd3, 16'd1);
        tbl[14] = mk(0, 0, 1, 1, 0, 16'h5555, 0, 16'h0000, 16'd3, 16'd1);
        tbl[15] = mk(0, 0, 1, 1, 0, 16'h5555, 0, 16'h0000, 16'd3, 16'd1);
        tbl[16] = mk(0, 0, 0, 0, 1, 16'h7777, 0, 16'h7777, 16'd0, 16'd0);
        tbl[17] = mk(0, 0, 0, 1, 0, 16'hBEEF, 1, 16'hBEEF, 16'd0, 16'd0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].in_valid,
                  tbl[i].clr, 37'(tbl[i].data));
            step();
            chk($sformatf("tbl%0d_valid", i), 64'(a_valid), 64'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_data", i),  64'(a_data),  64'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_stall_cnt", i),  64'(a_sc), 64'(tbl[i].exp_sc));
            chk($sformatf("tbl%0d_squash_cnt", i), 64'(a_qc), 64'(tbl[i].exp_qc));
        end

        // 4-bit counter saturation, then clear while still stalling
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 0, 1, 0, 37'h0);
            step();
            chk($sformatf("sat_stall_cnt_%0d", i), 64'(b_sc), 64'((i > 15) ? 15 : i));
        end
        drive(0, 1, 0, 1, 1, 37'h0);
        step();
        chk("clr_stall_cnt", 64'(b_sc), 64'd0);
        chk("clr_keeps_valid", 64'(b_valid), 64'd1);
        drive(0, 1, 0, 1, 0, 37'h0);
        step();
        chk("post_clr_stall_cnt", 64'(b_sc), 64'd1);

        // Reset wins over simultaneous stall and flush on the wide instance
        rd = 37'({$urandom(), $urandom()});
        drive(0, 0, 0, 1, 0, rd);
        step();
        chk("wide_load", 64'(b_data), 64'(rd));
        drive(0, 1, 0, 1, 0, ~rd);
        step();
        step();
        drive(1, 1, 1, 1, 0, ~rd);
        step();
        chk("rst_mid_data",   64'(b_data), 64'(B_BUB));
        chk("rst_mid_valid",  64'(b_valid), 64'd0);
        chk("rst_mid_stall",  64'(b_sc), 64'd0);
        chk("rst_mid_squash", 64'(b_qc), 64'd0);
        drive(0, 1, 0, 1, 0, rd);
        step();
        chk("post_rst_empty", 64'(b_valid), 64'd0);
        chk("post_rst_stall", 64'(b_sc), 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), 37'({$urandom(), $urandom()}));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
